fft_seq_ctrl: RTL
=================

Name: fft_seq_ctrl

Overview:
- Parametrised sequencer for the 4-bank in-place FFT datapath (rfft_4pt256 family).
- Replaces the free-running counter and latch-style stage logic with a registered FSM.
- Handles a start/done handshake, a valid/ready input load, per-stage bank address and crossbar generation, twiddle index and bypass control, and a streamed unload.
- Sits between the host stream interface and the butterfly datapath and its four memory banks.

Parameters:
LOG2N, 8, log2 of FFT length N; legal range 4..12
ADDR_BIT, LOG2N-2, bank address width; MEM_HEIGHT = 2**ADDR_BIT words per bank
PIPE_LAT, 3, butterfly pipeline depth in cycles (read to write-back); 1..8
BYPASS_STAGES, 4, number of leading stages (s < BYPASS_STAGES) with twiddle multiply bypassed
STAGE_W, 4, width of the stage output; must satisfy 2**STAGE_W > ADDR_BIT

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin transform; sampled only in IDLE
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on the last unload beat
in_valid  in  1  input word group present
in_ready  out  1  high in LOAD
mem_en  out  1  bank read enable
mem_we  out  1  bank write enable
rd_addr  out  4*ADDR_BIT  bank 0..3 read addresses; bank k at [k*ADDR_BIT +: ADDR_BIT]
wr_addr  out  4*ADDR_BIT  bank 0..3 write addresses, same packing
sel_ext  out  1  1 = bank write data comes from the external input
xbar_sel  out  2  input crossbar mode: 0 straight, 1 swap-low, 2 swap-high
pair_swap  out  1  output pair swap
stage  out  STAGE_W  current compute stage s
tw_idx  out  LOG2N-1  twiddle ROM index
bypass_en  out  1  twiddle bypass
out_valid  out  1  bank read data valid for the host

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset state: IDLE; every output 0; all counters 0.
- Reset mid-operation: returns to IDLE with no done pulse.
- All outputs are registered.
- FSM states: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD, FLUSH.
- IDLE: on start=1, go to LOAD next cycle with cnt=0.
- LOAD:
  - in_ready=1, sel_ext=1.
  - On in_valid: mem_we=1, all four wr_addr fields = cnt, cnt increments.
  - When cnt==MEM_HEIGHT-1 is accepted, go to COMPUTE with s=0, cnt=0.
  - in_valid=0 stalls LOAD with no write.
- COMPUTE (MEM_HEIGHT cycles per stage):
  - mem_en=1.
  - Banks 0,1 read at cnt; banks 2,3 read at cnt XOR mask(s), where mask(s) = top s bits of ADDR_BIT set (s=0 gives mask 0).
  - With b = max(ADDR_BIT-1-s, 0):
    - s=0: xbar_sel=0.
    - s>=1: xbar_sel=1 if cnt[ADDR_BIT-1:b]==0, else 2 if cnt[b]==1, else 0.
    - pair_swap = cnt[b] for s<ADDR_BIT; pair_swap = 0 for s=ADDR_BIT.
  - tw_idx = (cnt << s) truncated to LOG2N-1 bits.
  - bypass_en = (s < BYPASS_STAGES).
- Write-back:
  - wr_addr and mem_we equal rd_addr and mem_en delayed by exactly PIPE_LAT cycles.
  - This holds across stage boundaries and into DRAIN.
- DRAIN:
  - PIPE_LAT cycles with mem_en=0 while write-back completes.
  - Then s increments and the FSM returns to COMPUTE.
  - After the drain of stage s=ADDR_BIT (ADDR_BIT+1 stages total), go to UNLOAD.
- UNLOAD:
  - MEM_HEIGHT cycles; mem_en=1, all rd_addr fields = cnt, mem_we=0.
  - out_valid = mem_en delayed 1 cycle (bank read latency).
- FLUSH: one cycle emitting the final out_valid with done=1, then IDLE.
- Timing with continuous in_valid: done asserts at cycle MEM_HEIGHT + (ADDR_BIT+1)*(MEM_HEIGHT+PIPE_LAT) + MEM_HEIGHT + 1 after the start edge.
- start while busy: ignored.
- start coincident with rst: rst wins.
- cnt wraps to 0 at every state or stage transition; no carry leaks into stage.

Optional Feature:
FFT_SEQ_ABORT_EN:
- Defined: adds input abort (1 bit) and output aborted (1 bit).
- abort=1 in any busy state forces IDLE on the next edge.
- In that cycle mem_en and mem_we are 0 and in-flight delayed writes are squashed.
- aborted pulses for 1 cycle; done is not asserted.
- Undefined: the ports do not exist and behaviour is as above.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> all outputs 0, busy=0, no LOAD entry.
- Full run: LOG2N=8, PIPE_LAT=3, continuous in_valid:
  - busy rises 1 cycle after start.
  - done pulses exactly at cycle 598.
  - 64 out_valid beats with rd_addr 0..63.
- Load stall: in_valid low for cycles 10-14 of LOAD -> no mem_we in those cycles; wr_addr resumes at 10; done shifts by +5.
- Stage addressing, s=2, cnt=5:
  - rd_addr bank2/3 = 5 XOR 48 = 53, banks 0/1 = 5.
  - tw_idx = 20, xbar_sel=1, bypass_en=1.
  - wr_addr bank2 = 53 exactly 3 cycles later.
- Final stage s=6, cnt=63 -> bank2/3 address 0, pair_swap=0, bypass_en=0; DRAIN lasts 3 cycles, then UNLOAD.
- Abort (FFT_SEQ_ABORT_EN): abort mid-COMPUTE s=3 -> next cycle busy=0, aborted=1, mem_we=0 thereafter, done never pulses; new start runs to completion.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: registered load/compute/drain/unload sequencer for the 4-bank in-place FFT.
// Define FFT_SEQ_ABORT_EN to add the abort input and aborted pulse output.
module fft_seq_ctrl #(
    parameter int unsigned LOG2N         = 8,
    parameter int unsigned ADDR_BIT      = LOG2N - 2,
    parameter int unsigned PIPE_LAT      = 3,
    parameter int unsigned BYPASS_STAGES = 4,
    parameter int unsigned STAGE_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
`ifdef FFT_SEQ_ABORT_EN
    input  logic                    abort,
    output logic                    aborted,
`endif
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [4*ADDR_BIT-1:0]   rd_addr,
    output logic [4*ADDR_BIT-1:0]   wr_addr,
    output logic                    sel_ext,
    output logic [1:0]              xbar_sel,
    output logic                    pair_swap,
    output logic [STAGE_W-1:0]      stage,
    output logic [LOG2N-2:0]        tw_idx,
    output logic                    bypass_en,
    output logic                    out_valid
);

    localparam int unsigned TW_W    = LOG2N - 1;
    localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StCompute, StDrain, StUnload, StFlush
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_BIT-1:0]   cnt_q, cnt_d;
    logic [STAGE_W-1:0]    stage_q, stage_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  kill;
    logic                  load_we;

    logic [ADDR_BIT-1:0]   mask;
    logic                  hi_zero;
    logic                  bsel;
    int                    b;
    logic [4*ADDR_BIT-1:0] rd_d;
    logic [1:0]            xbar_d;
    logic                  pair_d;
    logic [TW_W-1:0]       tw_d;
    logic                  byp_d;
    logic                  comp_d;
    logic                  unl_d;

    // Write-back delay line: position i holds the read issued i+1 cycles earlier.
    logic                  pipe_v    [PIPE_LAT];
    logic [4*ADDR_BIT-1:0] pipe_addr [PIPE_LAT];

`ifdef FFT_SEQ_ABORT_EN
    assign kill = abort && (state_q != StIdle);
`else
    assign kill = 1'b0;
`endif

    assign load_we = (state_q == StLoad) && in_valid && !kill;
    assign stage   = stage_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    cnt_d = cnt_q + ADDR_BIT'(1);
                    if (&cnt_q) state_d = StCompute;
                end
            end
            StCompute: begin
                cnt_d = cnt_q + ADDR_BIT'(1);
                if (&cnt_q) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
                    drain_d = '0;
                    cnt_d   = '0;
                    if (stage_q == STAGE_W'(ADDR_BIT)) begin
                        state_d = StUnload;
                        stage_d = '0;
                    end else begin
                        state_d = StCompute;
                        stage_d = stage_q + STAGE_W'(1);
                    end
                end
            end
            StUnload: begin
                cnt_d = cnt_q + ADDR_BIT'(1);
                if (&cnt_q) state_d = StFlush;
            end
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill) begin
            state_d = StIdle;
            cnt_d   = '0;
            stage_d = '0;
            drain_d = '0;
        end
    end

    // Output decode from next-state values so the registered outputs line up with state_q.
    always_comb begin
        comp_d  = (state_d == StCompute);
        unl_d   = (state_d == StUnload);
        mask    = '0;
        hi_zero = 1'b1;
        bsel    = 1'b0;
        b       = (int'(stage_d) + 1 >= int'(ADDR_BIT)) ? 0 : int'(ADDR_BIT) - 1 - int'(stage_d);
        for (int i = 0; i < int'(ADDR_BIT); i++) begin
            if (int'(stage_d) + i >= int'(ADDR_BIT)) mask[i] = 1'b1;
            if (i >= b && cnt_d[i]) hi_zero = 1'b0;
            if (i == b) bsel = cnt_d[i];
        end

        rd_d   = '0;
        xbar_d = 2'd0;
        pair_d = 1'b0;
        tw_d   = '0;
        byp_d  = 1'b0;
        if (comp_d) begin
            for (int k = 0; k < 4; k++) begin
                rd_d[k*ADDR_BIT +: ADDR_BIT] = (k >= 2) ? (cnt_d ^ mask) : cnt_d;
            end
            if (stage_d != '0) begin
                if (hi_zero)   xbar_d = 2'd1;
                else if (bsel) xbar_d = 2'd2;
            end
            pair_d = (int'(stage_d) < int'(ADDR_BIT)) ? bsel : 1'b0;
            tw_d   = TW_W'(cnt_d) << stage_d;
            byp_d  = (int'(stage_d) < int'(BYPASS_STAGES));
        end else if (unl_d) begin
            rd_d = {4{cnt_d}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            stage_q   <= '0;
            drain_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            sel_ext   <= 1'b0;
            xbar_sel  <= 2'd0;
            pair_swap <= 1'b0;
            tw_idx    <= '0;
            bypass_en <= 1'b0;
            out_valid <= 1'b0;
`ifdef FFT_SEQ_ABORT_EN
            aborted   <= 1'b0;
`endif
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_addr[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            drain_q   <= drain_d;
            busy      <= (state_d != StIdle);
            done      <= (state_d == StFlush);
            in_ready  <= (state_d == StLoad);
            mem_en    <= comp_d || unl_d;
            rd_addr   <= rd_d;
            xbar_sel  <= xbar_d;
            pair_swap <= pair_d;
            tw_idx    <= tw_d;
            bypass_en <= byp_d;
            // Load writes trail acceptance by one cycle, so the source select trails LOAD too.
            sel_ext   <= (state_q == StLoad) && !kill;
            out_valid <= (state_q == StUnload) && !kill;
`ifdef FFT_SEQ_ABORT_EN
            aborted   <= kill;
`endif
            mem_we    <= load_we || (pipe_v[PIPE_LAT-1] && !kill);
            wr_addr   <= load_we ? {4{cnt_q}} : pipe_addr[PIPE_LAT-1];

            pipe_v[0]    <= comp_d && !kill;
            pipe_addr[0] <= rd_d;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                pipe_v[i]    <= pipe_v[i-1] && !kill;
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

endmodule
